// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
package uart_pkg;
  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_ODD   = 3'd1,
    PAR_EVEN  = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } par_mode_e;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} tx_state_e;

  localparam int   MIN_DBITS = 5;
  localparam logic LINE_IDLE = 1'b1;

  function automatic logic [3:0] clamp_dbits(input logic [3:0] d, input logic [3:0] max_d);
    logic [3:0] r;
    r = d;
    if (d < 4'(MIN_DBITS)) r = 4'(MIN_DBITS);
    else if (d > max_d)    r = max_d;
    return r;
  endfunction

  // Reserved encodings fall back to no parity.
  function automatic par_mode_e decode_par(input logic [2:0] p);
    return (p > 3'd4) ? PAR_NONE : par_mode_e'(p);
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period down-counter; bit_end marks the last clk cycle of each bit.
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             bit_end
);
  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign bit_end = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (restart || bit_end) cnt_d = div;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: runtime data length, parity mode and stop bits,
// valid/ready input with gap-free back-to-back frames.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [3:0]        cfg_dbits,
  input  logic [2:0]        cfg_par,
  input  logic              cfg_stop,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              dout,
  output logic              busy,
  output logic              frame_done
);
  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [3:0]        bitcnt_q, bitcnt_d, dbits_q, dbits_d;
  par_mode_e         par_q, par_d;
  logic              par_bit_q, par_bit_d, stop2_q, stop2_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              rdy_q;
  logic              bit_end, last_stop, accept;
  logic [3:0]        dbits_in;
  par_mode_e         par_in;
  logic [DATA_W-1:0] mask;
  logic              data_x;

  assign last_stop  = bit_end && ((state_q == STOP1 && !stop2_q) || state_q == STOP2);
  assign tx_ready   = rdy_q && (state_q == IDLE || last_stop);
  assign accept     = tx_valid && tx_ready;
  assign busy       = (state_q != IDLE);
  assign frame_done = last_stop;

  // The new word's divider is loaded on the accept cycle itself.
  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (accept),
    .div     (accept ? cfg_div : div_q),
    .bit_end (bit_end)
  );

  // Parity is fixed at accept time over the bits that will actually be sent.
  always_comb begin
    dbits_in = clamp_dbits(cfg_dbits, 4'(DATA_W));
    par_in   = decode_par(cfg_par);
    mask     = '0;
    for (int i = 0; i < DATA_W; i++) mask[i] = (i < int'(dbits_in));
    data_x   = ^(tx_data & mask);
  end

  always_comb begin
    dout = LINE_IDLE;
    case (state_q)
      START:   dout = 1'b0;
      DATA:    dout = shreg_q[0];
      PARITY:  dout = par_bit_q;
      default: dout = LINE_IDLE;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    dbits_d   = dbits_q;
    par_d     = par_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    div_d     = div_q;
    case (state_q)
      START: if (bit_end) begin
        state_d  = DATA;
        bitcnt_d = '0;
      end
      DATA: if (bit_end) begin
        shreg_d  = shreg_q >> 1;
        bitcnt_d = bitcnt_q + 4'd1;
        if (bitcnt_q == dbits_q - 4'd1) state_d = (par_q == PAR_NONE) ? STOP1 : PARITY;
      end
      PARITY: if (bit_end) state_d = STOP1;
      STOP1:  if (bit_end) state_d = stop2_q ? STOP2 : IDLE;
      STOP2:  if (bit_end) state_d = IDLE;
      default: ;
    endcase
    if (accept) begin
      state_d  = START;
      shreg_d  = tx_data;
      dbits_d  = dbits_in;
      par_d    = par_in;
      stop2_d  = cfg_stop;
      div_d    = cfg_div;
      case (par_in)
        PAR_ODD:  par_bit_d = ~data_x;
        PAR_EVEN: par_bit_d = data_x;
        PAR_MARK: par_bit_d = 1'b1;
        default:  par_bit_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      dbits_q   <= '0;
      par_q     <= PAR_NONE;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      div_q     <= '0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      dbits_q   <= dbits_d;
      par_q     <= par_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      div_q     <= div_d;
      rdy_q     <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed checks for uart_tx_cfg: frame shape, timing, parity, clamping, handshake.
module tb_uart_tx_cfg;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cfg_div = '0;
  logic [3:0]  cfg_dbits = '0;
  logic [2:0]  cfg_par = '0;
  logic        cfg_stop = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready, dout, busy, frame_done;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_W(8), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_div(cfg_div), .cfg_dbits(cfg_dbits), .cfg_par(cfg_par),
    .cfg_stop(cfg_stop), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .dout(dout), .busy(busy), .frame_done(frame_done)
  );

  // exp[k] is the level of bit k of the frame, bit 0 being the start bit.
  task automatic check_frame(input string nm, input logic [7:0] d, input int div, input int dbits,
                             input int par, input bit stop, input logic [15:0] exp, input int nbits);
    logic        seq [0:299];
    logic [15:0] got;
    int          done_c;
    bit          uni;
    @(negedge clk);
    cfg_div = 16'(div); cfg_dbits = 4'(dbits); cfg_par = 3'(par); cfg_stop = stop;
    tx_data = d; tx_valid = 1'b1;
    checks++;
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL %s ready_idle got %b exp 1", nm, tx_ready); end
    @(posedge clk); #1 tx_valid = 1'b0;
    done_c = 0;
    for (int c = 1; c < 300; c++) begin
      @(negedge clk);
      seq[c] = dout;
      if (c == 1) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s busy got %b exp 1", nm, busy); end
      end
      if (frame_done === 1'b1) begin done_c = c; break; end
    end
    checks++;
    if (done_c != nbits * (div + 1)) begin
      errors++; $display("FAIL %s length got %0d exp %0d", nm, done_c, nbits * (div + 1));
    end
    if (done_c == 0) return;
    got = '0;
    uni = 1'b1;
    for (int k = 0; k < nbits; k++) begin
      got[k] = seq[k * (div + 1) + 1];
      for (int j = 1; j <= div; j++)
        if (k * (div + 1) + 1 + j <= done_c && seq[k * (div + 1) + 1 + j] !== got[k]) uni = 1'b0;
    end
    checks++;
    if (got !== exp) begin errors++; $display("FAIL %s pattern got %h exp %h", nm, got, exp); end
    checks++;
    if (!uni) begin errors++; $display("FAIL %s bit_width got uneven exp %0d cycles", nm, div + 1); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dout !== 1'b1)
      begin errors++; $display("FAIL %s idle_after got busy=%b dout=%b exp 0/1", nm, busy, dout); end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({dout, busy, tx_ready, frame_done} !== 4'b1000)
      begin errors++; $display("FAIL reset_state got %b exp 1000", {dout, busy, tx_ready, frame_done}); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b exp 1", tx_ready); end
    cfg_div = 16'd3; cfg_dbits = 4'd8; cfg_par = 3'd0; cfg_stop = 1'b0; tx_data = 8'h00; tx_valid = 1'b1;
    @(posedge clk); #1 tx_valid = 1'b0;
    repeat (14) @(negedge clk);
    checks++;
    if (dout !== 1'b0 || busy !== 1'b1)
      begin errors++; $display("FAIL mid_data got dout=%b busy=%b exp 0/1", dout, busy); end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({dout, busy, tx_ready} !== 3'b100)
      begin errors++; $display("FAIL async_reset got %b exp 100", {dout, busy, tx_ready}); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1 || frame_done !== 1'b0)
      begin errors++; $display("FAIL reset_release got rdy=%b done=%b exp 1/0", tx_ready, frame_done); end
  endtask

  task automatic test_basic;
    check_frame("8n1_a5", 8'hA5, 3, 8, 0, 1'b0, {1'b1, 8'hA5, 1'b0}, 10);
  endtask

  task automatic test_parity;
    check_frame("even_53", 8'h53, 1, 7, 2, 1'b0, {1'b1, 1'b0, 7'h53, 1'b0}, 10);
    check_frame("odd_53",  8'h53, 1, 7, 1, 1'b0, {1'b1, 1'b1, 7'h53, 1'b0}, 10);
    check_frame("mark_53", 8'h53, 1, 7, 3, 1'b0, {1'b1, 1'b1, 7'h53, 1'b0}, 10);
    check_frame("space_01", 8'h01, 1, 7, 4, 1'b0, {1'b1, 1'b0, 7'h01, 1'b0}, 10);
    check_frame("rsvd_par", 8'h53, 1, 7, 7, 1'b0, {1'b1, 7'h53, 1'b0}, 9);
  endtask

  task automatic test_clamp;
    check_frame("clamp_lo", 8'hEA, 2, 3, 2, 1'b0, {1'b1, 1'b0, 5'b01010, 1'b0}, 8);
    check_frame("clamp_hi", 8'h3C, 0, 12, 0, 1'b1, {2'b11, 8'h3C, 1'b0}, 11);
  endtask

  task automatic test_back_to_back;
    logic [21:0] got;
    logic [21:0] exp;
    int          done_n;
    exp = {2'b11, 8'hF0, 1'b0, 2'b11, 8'h0F, 1'b0};
    got = '0;
    done_n = 0;
    @(negedge clk);
    cfg_div = 16'd0; cfg_dbits = 4'd8; cfg_par = 3'd0; cfg_stop = 1'b1; tx_data = 8'h0F; tx_valid = 1'b1;
    @(posedge clk); #1 tx_data = 8'hF0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      got[c - 1] = dout;
      if (frame_done === 1'b1) done_n++;
      if (c == 10 || c == 11 || c == 12) begin
        checks++;
        if (tx_ready !== (c == 11))
          begin errors++; $display("FAIL b2b_ready_c%0d got %b exp %b", c, tx_ready, c == 11); end
      end
      if (c == 12) tx_valid = 1'b0;
    end
    checks++;
    if (got !== exp) begin errors++; $display("FAIL b2b_pattern got %h exp %h", got, exp); end
    checks++;
    if (done_n != 2) begin errors++; $display("FAIL b2b_done_count got %0d exp 2", done_n); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", busy); end
  endtask

  task automatic test_cfg_isolation;
    fork
      check_frame("iso_first", 8'h01, 1, 8, 2, 1'b0, {1'b1, 1'b1, 8'h01, 1'b0}, 11);
      begin
        repeat (6) @(negedge clk);
        cfg_div = 16'd7; cfg_par = 3'd1;
      end
    join
    check_frame("iso_second", 8'h01, 7, 8, 1, 1'b0, {1'b1, 1'b0, 8'h01, 1'b0}, 11);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_clamp();
    test_back_to_back();
    test_cfg_isolation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART serial transmitter, successor to the fixed 8-bit transmitter. Adds a programmable baud divider, runtime data length (5..DATA_W), five parity modes, 1/2 stop bits, and a valid/ready input handshake with gap-free back-to-back frames. Sits between a byte-producing client (CPU/FIFO) and the serial pin.

Parameters:
DATA_W, 8, maximum data bits per frame (legal 5..9)
DIV_W, 16, width of the baud divider configuration

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted when 0)
cfg_div  in  DIV_W  bit period minus one, in clk cycles
cfg_dbits  in  4  data bits per frame, runtime
cfg_par  in  3  parity mode: 000 none, 001 odd, 010 even, 011 mark, 100 space, others treated as none
cfg_stop  in  1  0 = one stop bit, 1 = two stop bits
tx_data  in  DATA_W  payload, LSB transmitted first
tx_valid  in  1  client has a word
tx_ready  out  1  block accepts tx_data this cycle
dout  out  1  serial line, idle high
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse at end of last stop bit

Behaviour:
- Reset (rst=0, async): state IDLE, dout=1, busy=0, tx_ready=0 while asserted, frame_done=0, shift/config registers cleared, divider count 0.
- tx_ready=1 in IDLE, and also in the final clk cycle of the last stop bit; 0 otherwise.
- Accept = tx_valid & tx_ready. On accept: latch tx_data, cfg_dbits, cfg_par, cfg_stop, cfg_div; next cycle dout=0 (start bit), busy=1, divider restarts. Config changes mid-frame have no effect.
- Each bit lasts exactly cfg_div+1 clk cycles. cfg_div=0 gives one bit per cycle.
- States: IDLE -> START -> DATA (dbits bits, LSB first) -> PARITY (skipped if mode none) -> STOP1 -> STOP2 (only if cfg_stop=1) -> IDLE, or directly -> START when accepted in the final stop-bit cycle.
- Effective dbits = clamp(cfg_dbits, 5, DATA_W). Data bits at index >= dbits are ignored.
- Parity is computed over the dbits transmitted bits only:
  - even: parity bit = XOR of the bits.
  - odd: parity bit = XNOR of the bits.
  - mark: 1.
  - space: 0.
- Stop bits: dout=1.
- frame_done pulses for one cycle, coincident with the final cycle of the last stop bit.
- Frame length in clk cycles = (1 + dbits + P + S) * (cfg_div+1), where P is 0/1 for parity and S is 1/2 stop bits.
- Back-to-back: no idle cycle between the last stop bit and the next start bit when tx_valid is held.
- busy=0 only in IDLE.
- Reset mid-frame: dout returns to 1 immediately (async). No frame_done. The word is lost.
- tx_valid while tx_ready=0: ignored. The client must hold the word.

Decomposition:
- Package uart_pkg holds:
  - parity-mode enum (PAR_NONE, PAR_ODD, PAR_EVEN, PAR_MARK, PAR_SPACE);
  - FSM state enum (IDLE, START, DATA, PARITY, STOP1, STOP2);
  - constants MIN_DBITS=5 and LINE_IDLE=1'b1.
- One sub-module, uart_baud_gen:
  - down-counter loaded with cfg_div, with a restart input;
  - outputs a bit_end strobe in the last cycle of each bit period.
- FSM, shift register, bit counter and parity logic stay in uart_tx_cfg.

Test Plan:
- Reset: rst=0 mid-DATA with cfg_div=3 -> dout=1, busy=0, tx_ready=0 immediately. After release, tx_ready=1 next cycle.
- Basic 8N1: cfg_div=3, dbits=8, par=none, stop=0, data 0xA5 -> dout = 0,1,0,1,0,0,1,0,1,1. Each bit lasts 4 cycles, 40 cycles total; frame_done in cycle 40.
- Even/odd parity: dbits=7, data 0x53 (4 ones) -> even sends parity 0, odd sends 1. Mark sends 1 and space sends 0 regardless of data.
- Clamping: cfg_dbits=3 -> 5 data bits sent. cfg_dbits=12 with DATA_W=8 -> 8 sent. Bits above dbits are not transmitted.
- Two stop bits, back-to-back: stop=1, tx_valid held with 0x0F then 0xF0 at cfg_div=0 -> STOP1, STOP2, then start bit of 0xF0 in the next cycle with no gap. tx_ready is high only in the final stop cycle.
- Config isolation: change cfg_div 1->7 and cfg_par even->odd mid-frame -> current frame keeps div=1/even; the next frame uses div=7/odd.
